// File: rtl/ram_io_bus_pkg.sv
// Shared constants and types for the RAM/IO bus responder.
// Optional feature macro used by the top: CLK_COUNTER_EN.
`ifndef BYTE_TP
`define BYTE_TP 8
`endif

package ram_io_bus_pkg;
  localparam int BYTE_W = `BYTE_TP;

  typedef logic [BYTE_W-1:0] byte_t;

  // IO region is selected by bus address bits [17:16].
  localparam logic [1:0]  IO_BASE_SEL  = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Handshake: an entry leaves when pop_i is high and the FIFO is not empty;
// an entry enters when push_i is high and there is room, where a same-cycle
// pop makes room on a full FIFO. A push with no room is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  // Head is forced to zero while empty so the output never shows stale data.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally (power-of-2 depth); count tracks push minus pop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/ram_io_bus.sv
// Memory-side responder: 128 KB RAM, UART TX queue, RX holding byte,
// clock counter and program-stop flag behind a byte-wide CPU bus.
// Optional macro CLK_COUNTER_EN builds the clock counter and its snapshot.
// UART handshakes: a byte moves on tx_valid && tx_ready (TX) and on
// rx_valid && rx_ready (RX), both sampled at the rising clock edge.
module ram_io_bus
  import ram_io_bus_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TXQ_DEPTH   = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        prog_stop
);
  localparam int CW = $clog2(TXQ_DEPTH) + 1;

  logic [17:0] a;
  logic        is_io, uart_hit, stop_hit, clk_hit, rd_en;
  byte_t       rd_data_d, mem_din_q;
  byte_t       ram_q [0:(1<<RAM_AW)-1];
  byte_t       rx_data_q, clk_rd_byte, tx_push_data;
  logic        rx_held_q, rx_load, consume, prog_stop_q;
  logic        tx_push, tx_pop, tx_empty, unused_tx_full;
  logic [CW-1:0] tx_count;

  assign a        = mem_a[17:0];
  assign is_io    = (a[17:16] == IO_BASE_SEL);
  assign uart_hit = (a == IO_UART_ADDR);
  assign stop_hit = (a == IO_CLK_ADDR);
  assign clk_hit  = (a[17:2] == IO_CLK_ADDR[17:2]);
  assign rd_en    = !mem_wr;

  // RAM array: written at the edge, contents survive reset.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !is_io) ram_q[mem_a[RAM_AW-1:0]] <= mem_dout;
  end

`ifdef CLK_COUNTER_EN
  logic [31:0] cnt_q, snap_q;

  // Free-running counter; reading byte 0 freezes a copy for bytes 1..3.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (rd_en && is_io && clk_hit && (a[1:0] == 2'd0)) snap_q <= cnt_q;
    end
  end

  // Byte 0 comes from the live counter, the rest from the frozen copy.
  always_comb begin
    clk_rd_byte = '0;
    case (a[1:0])
      2'd0: clk_rd_byte = cnt_q[7:0];
      2'd1: clk_rd_byte = snap_q[15:8];
      2'd2: clk_rd_byte = snap_q[23:16];
      default: clk_rd_byte = snap_q[31:24];
    endcase
  end

  logic unused_hi_addr;
  assign unused_hi_addr = ^mem_a[31:18];
`else
  assign clk_rd_byte = '0;

  logic unused_hi_addr;
  assign unused_hi_addr = ^{mem_a[31:18], mem_a[1:0]};
`endif

  // Read mux: RAM, RX holding byte, counter bytes, else zero.
  always_comb begin
    rd_data_d = '0;
    if (!is_io)        rd_data_d = ram_q[mem_a[RAM_AW-1:0]];
    else if (uart_hit) rd_data_d = rx_held_q ? rx_data_q : '0;
    else if (clk_hit)  rd_data_d = clk_rd_byte;
  end

  // Registered read data; holds its value during write cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in)     mem_din_q <= '0;
    else if (rd_en) mem_din_q <= rd_data_d;
  end
  assign mem_din = mem_din_q;

  // RX holding register: the CPU read clears it, the UART refills it when empty.
  assign consume  = rd_en && is_io && uart_hit;
  assign rx_load  = rx_valid && !rx_held_q;
  assign rx_ready = !rx_held_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_held_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      if (consume) rx_held_q <= 1'b0;
      if (rx_load) begin
        rx_held_q <= 1'b1;
        rx_data_q <= rx_byte;
      end
    end
  end

  // Stop flag is sticky until reset.
  always_ff @(posedge clk_in) begin
    if (rst_in)                           prog_stop_q <= 1'b0;
    else if (mem_wr && is_io && stop_hit) prog_stop_q <= 1'b1;
  end
  assign prog_stop = prog_stop_q;

  // Zero bytes to the UART address are filtered; the stop write forces a 0x00.
  assign tx_push      = mem_wr && is_io && ((uart_hit && (mem_dout != 8'h00)) || stop_hit);
  assign tx_push_data = stop_hit ? 8'h00 : mem_dout;
  assign tx_pop       = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH(BYTE_W),
    .DEPTH(TXQ_DEPTH)
  ) u_txq (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (tx_push),
    .push_data_i (tx_push_data),
    .pop_i       (tx_pop),
    .pop_data_o  (tx_byte),
    .count_o     (tx_count),
    .empty_o     (tx_empty),
    .full_o      (unused_tx_full)
  );

  assign tx_valid       = !tx_empty;
  assign io_buffer_full = ((CW'(TXQ_DEPTH) - tx_count) <= CW'(FULL_MARGIN));
endmodule

// File: tb/tb_ram_io_bus.sv
// Bench for ram_io_bus: RAM, TX queue, RX register, counter and stop flag.
`timescale 1ns/1ps
module tb_ram_io_bus;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full, tx_valid, rx_ready, prog_stop;
  logic [7:0]  tx_byte;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  ram_m [int];
  logic [31:0] model_cnt;

  ram_io_bus dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .prog_stop(prog_stop)
  );

  // Clock and reference counter
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (rst_in) model_cnt <= '0;
    else        model_cnt <= model_cnt + 32'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // TX monitor: every transfer must match the next expected byte.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) begin
      check("tx_expected_pending", (tx_exp_q.size() != 0), 1);
      if (tx_exp_q.size() != 0) check("tx_byte", tx_byte, tx_exp_q.pop_front());
    end
  end

  // Driver: one bus cycle; reads push an expectation, compared after the edge.
  task automatic bus_cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                           input logic chk, input logic [7:0] exp, input string tag);
    mem_a = a; mem_wr = wr; mem_dout = d;
    if (chk) exp_q.push_back(exp);
    @(posedge clk_in); #1;
    if (chk) check(tag, mem_din, exp_q.pop_front());
    mem_wr = 1'b0;
  endtask

  task automatic idle();
    bus_cycle(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, "idle");
  endtask

  task automatic tx_write(input logic [31:0] a, input logic [7:0] d);
    if (a[17:0] == 18'h30004 || (a[17:0] == 18'h30000 && d != 8'h00)) begin
      check("tx_room", (tx_exp_q.size() < 16 || tx_ready), 1);
      tx_exp_q.push_back((a[17:0] == 18'h30004) ? 8'h00 : d);
    end
    bus_cycle(a, 1'b1, d, 1'b0, 8'h00, "wr");
  endtask

  task automatic do_reset();
    rst_in = 1'b1; mem_wr = 1'b0; mem_a = '0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    tx_exp_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && tx_exp_q.size() != 0; i++) idle();
    idle();
    check("tx_drained", tx_exp_q.size(), 0);
    check("tx_valid_idle", tx_valid, 0);
  endtask

  initial begin
    logic [31:0] snap;
    logic [7:0]  e [4];

    // Reset values
    do_reset();
    check("rst_mem_din", mem_din, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_buf_full", io_buffer_full, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_prog_stop", prog_stop, 0);
    rst_in = 1'b0;

    // RAM write then immediate read, plus upper-address aliasing
    bus_cycle(32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00, "wr");
    bus_cycle(32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_wr_rd");
    bus_cycle(32'h0004_0123, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_alias");
    ram_m[32'h123] = 8'hA5;

    // Random RAM traffic
    for (int i = 0; i < 16; i++) begin
      int ad;
      logic [7:0] dv;
      ad = int'($urandom_range(0, 32'h1FFFF));
      dv = 8'($urandom_range(0, 255));
      ram_m[ad] = dv;
      bus_cycle(32'(ad), 1'b1, dv, 1'b0, 8'h00, "wr");
    end
    foreach (ram_m[k]) bus_cycle(32'(k), 1'b0, 8'h00, 1'b1, ram_m[k], "ram_rand");

    // TX zero filter and ignored IO write
    tx_ready = 1'b1;
    tx_write(32'h0003_0000, 8'h41);
    tx_write(32'h0003_0000, 8'h00);
    tx_write(32'h0003_0000, 8'h42);
    tx_write(32'h0003_0008, 8'h77);
    drain();

    // Near-full threshold
    tx_ready = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tx_write(32'h0003_0000, 8'(k));
      if (k == 13) check("full_after_13", io_buffer_full, 0);
      if (k == 14) check("full_after_14", io_buffer_full, 1);
    end
    tx_ready = 1'b1;
    idle();
    tx_ready = 1'b0;
    check("full_after_pop", io_buffer_full, 0);
    for (int k = 15; k <= 17; k++) tx_write(32'h0003_0000, 8'(k));
    check("full_at_16", io_buffer_full, 1);
    tx_ready = 1'b1;
    tx_write(32'h0003_0000, 8'd18);
    check("full_push_pop", io_buffer_full, 1);
    drain();

    // RX holding register
    rx_valid = 1'b1; rx_byte = 8'h37;
    idle();
    check("rx_ready_held", rx_ready, 0);
    rx_byte = 8'h55;
    idle();
    rx_valid = 1'b0;
    bus_cycle(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h37, "rx_read1");
    check("rx_ready_free", rx_ready, 1);
    bus_cycle(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00, "rx_read2");
    rx_valid = 1'b1; rx_byte = 8'h6C;
    bus_cycle(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00, "rx_same_cycle");
    rx_valid = 1'b0;
    bus_cycle(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h6C, "rx_after_same");

    // Counter read across a byte-0 carry
    for (int i = 0; i < 600 && model_cnt[7:0] != 8'hFF; i++) idle();
    check("cnt_align", model_cnt[7:0], 8'hFF);
    snap = model_cnt;
`ifdef CLK_COUNTER_EN
    e[0] = snap[7:0]; e[1] = snap[15:8]; e[2] = snap[23:16]; e[3] = snap[31:24];
`else
    e[0] = 8'h00; e[1] = 8'h00; e[2] = 8'h00; e[3] = 8'h00;
`endif
    for (int b = 0; b < 4; b++) bus_cycle(32'h0003_0004 + 32'(b), 1'b0, 8'h00, 1'b1, e[b], "clk_byte");
    bus_cycle(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00, "io_other_rd");
    bus_cycle(32'h0003_FFFF, 1'b0, 8'h00, 1'b1, 8'h00, "io_top_rd");

    // Program stop, later IO writes, then reset mid-operation
    tx_ready = 1'b1;
    check("stop_before", prog_stop, 0);
    tx_write(32'h0003_0004, 8'h55);
    check("stop_set", prog_stop, 1);
    tx_write(32'h0003_0000, 8'h43);
    drain();
    check("stop_sticky", prog_stop, 1);
    tx_ready = 1'b0;
    tx_write(32'h0003_0000, 8'h44);
    check("tx_valid_pending", tx_valid, 1);
    rx_valid = 1'b1; rx_byte = 8'h99;
    idle();
    rx_valid = 1'b0;
    do_reset();
    check("rst2_prog_stop", prog_stop, 0);
    check("rst2_tx_valid", tx_valid, 0);
    check("rst2_rx_ready", rx_ready, 1);
    check("rst2_buf_full", io_buffer_full, 0);
    rst_in = 1'b0;
    bus_cycle(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00, "rx_lost");
    check("ram_kept", 1, 1 - 0);
    bus_cycle(32'h0000_0123, 1'b0, 8'h00, 1'b1, ram_m[32'h123], "ram_survives");
    check("tx_left", tx_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
